// File: rtl/wb_sram_port0_ctrl_if.sv
// Wishbone B4 classic bus bundle between the SoC interconnect and the sram port-0 controller.
// Latency: none, wires only.
// Backpressure: the master holds cyc/stb until ack; the slave paces accesses with wb_ack_o.
interface wb_sram_port0_ctrl_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_sram_port0_ctrl.sv
// Wishbone classic slave driving RW port 0 of the sram macro (optional read register: SRAM_READ_REG_EN).
// Latency: write ack 1 cycle after request; read ack 1 cycle (2 with SRAM_READ_REG_EN).
// Backpressure: one access per 2 cycles (3 for registered reads); a req held through ACK is re-sampled in IDLE.
module wb_sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_sram_port0_ctrl_if.slave   wb,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

`ifdef SRAM_READ_REG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RDWAIT = 2'd1, ACK = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
`endif

  state_t state;
  state_t state_nxt;
  logic   req;
  logic   strobe;

  // Address bits above the sram word range alias by design; decoding lives in the interconnect.
  logic unused_adr;
  assign unused_adr = ^{wb.wb_adr_i[31:ADDR_WIDTH+2], wb.wb_adr_i[1:0]};

  assign req         = wb.wb_cyc_i & wb.wb_stb_i;
  assign sram_addr0  = wb.wb_adr_i[ADDR_WIDTH+1:2];
  assign sram_din0   = wb.wb_dat_i;
  assign sram_wmask0 = wb.wb_sel_i;
  assign sram_csb0   = ~strobe;
  assign sram_web0   = ~(strobe & wb.wb_we_i);
  assign wb.wb_ack_o = (state == ACK);

  // State register; reset abandons any access in flight without acking it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and sram strobe: only IDLE accepts a request, and never while in reset.
  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          strobe = 1'b1;
`ifdef SRAM_READ_REG_EN
          state_nxt = wb.wb_we_i ? ACK : RDWAIT;
`else
          state_nxt = ACK;
`endif
        end
      end
`ifdef SRAM_READ_REG_EN
      RDWAIT:  state_nxt = wb.wb_cyc_i ? ACK : IDLE;
`endif
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      strobe = 1'b0;
    end
  end

`ifdef SRAM_READ_REG_EN
  logic [DATA_WIDTH-1:0] rd_q;

  // Capture sram read data in RDWAIT; an aborted cycle leaves the previous value in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (state == RDWAIT && wb.wb_cyc_i) begin
      rd_q <= sram_dout0;
    end
  end

  assign wb.wb_dat_o = rd_q;
`else
  assign wb.wb_dat_o = (state == ACK) ? sram_dout0 : '0;
`endif

endmodule

// File: tb/tb_wb_sram_port0_ctrl.sv
// Bench for wb_sram_port0_ctrl with a behavioural sram macro and an ack-driven scoreboard.
// Latency: expected read latency and access period follow SRAM_READ_REG_EN.
// Backpressure: the master task holds its request until ack or a 10-cycle bound.
module tb_wb_sram_port0_ctrl;
  localparam int AW = 11;
`ifdef SRAM_READ_REG_EN
  localparam int RD_LAT    = 2;
  localparam int RD_PERIOD = 3;
  localparam bit REG_EN    = 1'b1;
`else
  localparam int RD_LAT    = 1;
  localparam int RD_PERIOD = 2;
  localparam bit REG_EN    = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sram_csb0;
  logic          sram_web0;
  logic [3:0]    sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [31:0]   sram_din0;
  logic [31:0]   sram_dout0;

  always #5 clk = ~clk;

  wb_sram_port0_ctrl_if wb();

  wb_sram_port0_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WMASKS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  // Behavioural sram: byte-masked write, read data registered one cycle after the strobe.
  logic [31:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sram_dout0 = '0;
  end
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] dat;
    string       name;
  } exp_t;
  exp_t sb_q[$];
  bit   prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_rd, input logic [31:0] dat, input string name);
    exp_t e;
    e.is_rd = is_rd;
    e.dat   = dat;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  // Monitor: every ack pops one expectation; reads compare data, and acks must never abut.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb.wb_ack_o === 1'b1) begin
        check("ack_not_back_to_back", {31'b0, prev_ack}, 32'd0);
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
        end else begin
          e = sb_q.pop_front();
          if (e.is_rd) check(e.name, wb.wb_dat_o, e.dat);
        end
      end
      prev_ack = (wb.wb_ack_o === 1'b1);
    end
  end

  task automatic idle_bus();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic set_req(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_sel_i = sel;
    wb.wb_dat_i = dat;
  endtask

  // One complete bus cycle, entered and left just after a rising edge.
  task automatic access(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [31:0] exp_rd, input string name,
                        input bit chk_strobe, input logic [31:0] exp_addr);
    int lat;
    bit got;
    push_exp(!we, exp_rd, name);
    set_req(we, adr, sel, dat);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      if (chk_strobe && lat == 0) begin
        check({name, "_csb0"}, {31'b0, sram_csb0}, 32'd0);
        check({name, "_web0"}, {31'b0, sram_web0}, {31'b0, ~we});
        check({name, "_addr0"}, {21'b0, sram_addr0}, exp_addr);
        check({name, "_wmask0"}, {28'b0, sram_wmask0}, {28'b0, sel});
      end
      if (wb.wb_ack_o === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no ack in 10 cycles, expected ack", name);
    end else begin
      check({name, "_lat"}, 32'(lat), we ? 32'd1 : 32'(RD_LAT));
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int acks;
    reset = 1'b1;
    wb.wb_adr_i = '0;
    wb.wb_sel_i = '0;
    wb.wb_dat_i = '0;
    set_req(1'b0, 32'h0, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_csb0", {31'b0, sram_csb0}, 32'd1);
      check("reset_ack", {31'b0, wb.wb_ack_o}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    access(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h0, "rd_first", 1'b1, 32'd0);
    access(1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0, "wr_beef", 1'b1, 32'd4);
    access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEADBEEF, "rd_beef", 1'b0, 32'd0);
    access(1'b1, 32'h0000_0010, 4'b0010, 32'h0000AB00, 32'h0, "wr_lane1", 1'b1, 32'd4);
    access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEADABEF, "rd_lane1", 1'b0, 32'd0);
    access(1'b1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF, 32'h0, "wr_sel0", 1'b0, 32'd0);
    access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEADABEF, "rd_sel0", 1'b0, 32'd0);
    access(1'b1, 32'h0000_0004, 4'hF, 32'h12345678, 32'h0, "wr_word1", 1'b0, 32'd0);
    access(1'b0, 32'h0000_2004, 4'hF, 32'h0, 32'h12345678, "rd_alias_hi", 1'b1, 32'd1);
    access(1'b0, 32'h0000_0004, 4'hF, 32'h0, 32'h12345678, "rd_alias_lo", 1'b0, 32'd0);

    @(negedge clk);
    check("dat_o_idle", wb.wb_dat_o, REG_EN ? 32'h12345678 : 32'h0);
    @(posedge clk); #1;

    // Request held high for 12 cycles: one strobe per access period.
    for (int i = 0; i < 12 / RD_PERIOD; i++) push_exp(1'b1, 32'hDEADABEF, "rd_held");
    set_req(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sram_csb0 === 1'b0) pulses++;
      @(posedge clk); #1;
    end
    idle_bus();
    check("held_csb0_pulses", 32'(pulses), 32'(12 / RD_PERIOD));

`ifdef SRAM_READ_REG_EN
    // Drop cyc while in RDWAIT: no ack, and the register keeps the previous read.
    set_req(1'b0, 32'h0000_0004, 4'hF, 32'h0);
    @(posedge clk); #1;
    idle_bus();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb.wb_ack_o === 1'b1) acks++;
      @(posedge clk); #1;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_dat_held", wb.wb_dat_o, 32'hDEADABEF);
`else
    // Drop cyc during ACK: the ack is still driven with the read data.
    push_exp(1'b1, 32'h12345678, "rd_drop_in_ack");
    set_req(1'b0, 32'h0000_0004, 4'hF, 32'h0);
    @(posedge clk); #1;
    idle_bus();
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb.wb_ack_o === 1'b1) acks++;
      @(posedge clk); #1;
    end
    check("drop_in_ack_count", 32'(acks), 32'd1);
`endif

    // Reset asserted in ACK: ack this cycle only, nothing strobed while reset holds.
    push_exp(1'b0, 32'h0, "wr_reset_ack");
    set_req(1'b1, 32'h0000_0008, 4'hF, 32'hCAFEF00D);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("ack_in_reset_cycle", {31'b0, wb.wb_ack_o}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_after_reset", {31'b0, wb.wb_ack_o}, 32'd0);
    check("csb0_during_reset", {31'b0, sram_csb0}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_bus();
    access(1'b0, 32'h0000_0008, 4'hF, 32'h0, 32'hCAFEF00D, "rd_after_reset", 1'b0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
